axi4_lite_stats_poller: RTL and testbench

AXI4-Lite read-only master that sequences periodic sweeps of a block of status/counter registers on a DMA-side AXI4-Lite slave. Each sweep reads NUM_REGS consecutive registers. Every readback is emitted as a snapshot together with its modulo-2^32 delta against the previous sweep. It sits beside the DMA statistics slave and feeds monitoring logic, so software need not poll counters itself.

---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_stats_poller_if.sv | 28 ++
 rtl/stats_delta_store.sv | 47 ++++
 rtl/axi4_lite_stats_poller.sv | 194 +++++++++++++++++++
 tb/tb_axi4_lite_stats_poller.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and the stats poller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4_lite_pkg;

  localparam logic [1:0] AXI_RESP_OK     = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    POLL_IDLE = 2'd0,
    POLL_ADDR = 2'd1,
    POLL_DATA = 2'd2,
    POLL_WAIT = 2'd3
  } poller_state_t;

endpackage

// File: rtl/axi4_lite_stats_poller_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between the stats poller and the DMA stats slave.
// Latency: n/a (wires only).
// Backpressure: M_ARREADY / M_RVALID from the slave, M_RREADY from the master.
// Ports: M_ARADDR, M_ARVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID, M_RREADY.
interface axi4_lite_stats_poller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] M_ARADDR;
  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RVALID;
  logic                  M_RREADY;

  modport master (
    output M_ARADDR, M_ARVALID, M_RREADY,
    input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );

  modport slave (
    input  M_ARADDR, M_ARVALID, M_RREADY,
    output M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );

endinterface

// File: rtl/stats_delta_store.sv
// Per-register storage of the last good readback and its valid flag.
// Latency: write takes effect next cycle; read is combinational.
// Backpressure: none, accepts a write every cycle.
// Ports: ACLK/ARESETN, we/wr_idx/wr_data write side, rd_idx -> rd_data/rd_vld read side.
module stats_delta_store #(
  parameter int NUM_REGS = 6
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        we,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data,
  output logic        rd_vld
);

  logic [31:0]         prev_q [NUM_REGS];
  logic [NUM_REGS-1:0] vld_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      vld_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) prev_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we && (wr_idx == 4'(i))) begin
          prev_q[i] <= wr_data;
          vld_q[i]  <= 1'b1;
        end
      end
    end
  end

  // Out-of-range indices read back as "no previous value".
  always_comb begin
    rd_data = '0;
    rd_vld  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_data = prev_q[i];
        rd_vld  = vld_q[i];
      end
    end
  end

endmodule

// File: rtl/axi4_lite_stats_poller.sv
// AXI4-Lite read master sweeping NUM_REGS stats registers, emitting snapshot + delta per read.
// Latency: >= 3 cycles per register (ADDR, slave response, DATA); snapshot registered 1 cycle after R handshake.
// Backpressure: holds ARVALID/ARADDR until ARREADY; one transaction outstanding; RREADY only in DATA.
// Ports: ACLK, ARESETN (sync, active-low), enable, period, base_addr, m_axi (AR/R master),
//        snap_* snapshot stream, sweep_done, err_count, busy.
// Optional: define STATS_POLLER_THRESH_EN to add THRESH parameter, irq output and irq_clr input.
module axi4_lite_stats_poller
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 6,
  parameter int ADDR_STRIDE   = 1,
  parameter int ERR_CNT_WIDTH = 16
`ifdef STATS_POLLER_THRESH_EN
  ,
  parameter logic [31:0] THRESH = 32'h1000
`endif
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     enable,
  input  logic [31:0]              period,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  axi4_lite_stats_poller_if.master m_axi,
  output logic                     snap_valid,
  output logic [3:0]               snap_index,
  output logic [31:0]              snap_data,
  output logic [31:0]              snap_delta,
  output logic                     snap_first,
  output logic                     snap_err,
  output logic                     sweep_done,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     busy
`ifdef STATS_POLLER_THRESH_EN
  ,
  output logic                     irq,
  input  logic                     irq_clr
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  poller_state_t           state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [31:0]             wait_q, wait_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  logic [DATA_WIDTH-1:0]   rdata;
  logic                    r_hs;
  logic                    resp_ok;
  logic [31:0]             prev_data;
  logic                    prev_vld;
  logic [31:0]             delta_d;

  assign rdata   = m_axi.M_RDATA;
  assign r_hs    = (state_q == POLL_DATA) && m_axi.M_RVALID;
  assign resp_ok = (m_axi.M_RRESP == AXI_RESP_OK);
  // Errors and first reads both report a zero delta; subtraction wraps mod 2^32.
  assign delta_d = (resp_ok && prev_vld) ? (rdata - prev_data) : 32'd0;

  stats_delta_store #(
    .NUM_REGS (NUM_REGS)
  ) u_store (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .we      (r_hs && resp_ok),
    .wr_idx  (idx_q),
    .wr_data (rdata),
    .rd_idx  (idx_q),
    .rd_data (prev_data),
    .rd_vld  (prev_vld)
  );

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_q <= POLL_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      idx_q  <= '0;
      base_q <= '0;
      wait_q <= '0;
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
      wait_q <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    wait_d  = wait_q;
    unique case (state_q)
      POLL_IDLE: begin
        if (enable) begin
          state_d = POLL_ADDR;
          idx_d   = '0;
          base_d  = base_addr;
        end
      end
      POLL_ADDR: begin
        if (m_axi.M_ARREADY) state_d = POLL_DATA;
      end
      POLL_DATA: begin
        if (m_axi.M_RVALID) begin
          // A dropped enable stops after the read in flight, even mid-sweep.
          if (!enable) begin
            state_d = POLL_IDLE;
          end else if (idx_q < LAST_IDX) begin
            state_d = POLL_ADDR;
            idx_d   = idx_q + 4'd1;
          end else if (period == 32'd0) begin
            state_d = POLL_ADDR;
            idx_d   = '0;
            base_d  = base_addr;
          end else begin
            state_d = POLL_WAIT;
            wait_d  = period;
          end
        end
      end
      POLL_WAIT: begin
        if (!enable) begin
          state_d = POLL_IDLE;
        end else if (wait_q <= 32'd1) begin
          state_d = POLL_ADDR;
          idx_d   = '0;
          base_d  = base_addr;
        end else begin
          wait_d = wait_q - 32'd1;
        end
      end
      default: state_d = POLL_IDLE;
    endcase
  end

  // Output logic; address is derived from registers only, so it is stable while ARVALID waits.
  always_comb begin
    m_axi.M_ARVALID = (state_q == POLL_ADDR);
    m_axi.M_RREADY  = (state_q == POLL_DATA);
    m_axi.M_ARADDR  = base_q + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STRIDE);
    busy            = (state_q != POLL_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      snap_valid <= 1'b0;
      snap_index <= '0;
      snap_data  <= '0;
      snap_delta <= '0;
      snap_first <= 1'b0;
      snap_err   <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      snap_valid <= r_hs;
      sweep_done <= r_hs && (idx_q == LAST_IDX);
      if (r_hs) begin
        snap_index <= idx_q;
        snap_data  <= rdata;
        snap_delta <= delta_d;
        snap_first <= !prev_vld;
        snap_err   <= !resp_ok;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN)                                   err_cnt_q <= '0;
    else if (r_hs && !resp_ok && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;

`ifdef STATS_POLLER_THRESH_EN
  logic irq_q;

  // Set has priority over clear so an exceed coincident with irq_clr is not lost.
  always_ff @(posedge ACLK) begin
    if (!ARESETN)                                           irq_q <= 1'b0;
    else if (r_hs && resp_ok && prev_vld && (delta_d > THRESH)) irq_q <= 1'b1;
    else if (irq_clr)                                       irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_axi4_lite_stats_poller.sv
// Directed bench for axi4_lite_stats_poller with a simple AXI4-Lite slave model.
// Latency: n/a. Backpressure: slave model inserts programmable AR/R delays.
module tb_axi4_lite_stats_poller;
  import axi4_lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd0;
  logic [31:0] base_addr = 32'h40;
  logic        snap_valid, snap_first, snap_err, sweep_done, busy;
  logic [3:0]  snap_index;
  logic [31:0] snap_data, snap_delta;
  logic [1:0]  err_count;
`ifdef STATS_POLLER_THRESH_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  axi4_lite_stats_poller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_stats_poller #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .NUM_REGS      (6),
    .ADDR_STRIDE   (1),
    .ERR_CNT_WIDTH (2)
`ifdef STATS_POLLER_THRESH_EN
    ,
    .THRESH        (32'd10)
`endif
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .enable     (enable),
    .period     (period),
    .base_addr  (base_addr),
    .m_axi      (axi),
    .snap_valid (snap_valid),
    .snap_index (snap_index),
    .snap_data  (snap_data),
    .snap_delta (snap_delta),
    .snap_first (snap_first),
    .snap_err   (snap_err),
    .sweep_done (sweep_done),
    .err_count  (err_count),
    .busy       (busy)
`ifdef STATS_POLLER_THRESH_EN
    ,
    .irq        (irq),
    .irq_clr    (irq_clr)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] regs [16];
  int          err_idx  = 16;
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic        arv_s = 1'b0, ar_hs_s = 1'b0, r_hs_s = 1'b0;
  logic [31:0] addr_s = '0;

  initial begin
    forever begin
      @(negedge ACLK);
      arv_s   = axi.M_ARVALID;
      ar_hs_s = axi.M_ARVALID && axi.M_ARREADY;
      r_hs_s  = axi.M_RVALID && axi.M_RREADY;
      addr_s  = axi.M_ARADDR;
    end
  end

  initial begin
    int  arcnt, rcnt, ridx;
    logic pend;
    axi.M_ARREADY = 1'b0;
    axi.M_RVALID  = 1'b0;
    axi.M_RDATA   = '0;
    axi.M_RRESP   = AXI_RESP_OK;
    arcnt = 0; rcnt = 0; ridx = 0; pend = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        axi.M_ARREADY = (ar_delay == 0);
        axi.M_RVALID  = 1'b0;
        pend = 1'b0; arcnt = 0;
      end else begin
        if (r_hs_s) axi.M_RVALID = 1'b0;
        if (ar_hs_s) begin
          pend = 1'b1; rcnt = 0; arcnt = 0;
          ridx = int'(addr_s[3:0]);
        end else if (arv_s) begin
          arcnt++;
        end
        if (ar_delay == 0) axi.M_ARREADY = 1'b1;
        else axi.M_ARREADY = arv_s && !ar_hs_s && (arcnt >= ar_delay);
        if (pend && !axi.M_RVALID) begin
          if (rcnt >= r_delay) begin
            axi.M_RVALID = 1'b1;
            axi.M_RDATA  = regs[ridx];
            axi.M_RRESP  = (ridx == err_idx) ? AXI_RESP_SLVERR : AXI_RESP_OK;
            pend = 1'b0;
          end else begin
            rcnt++;
          end
        end
      end
    end
  end

  // ARVALID/ARADDR must hold while the slave stalls ARREADY.
  initial begin
    logic        pw;
    logic [31:0] pa;
    pw = 1'b0; pa = '0;
    forever begin
      @(negedge ACLK);
      if (pw) begin
        check("ar_hold_valid", axi.M_ARVALID, 1);
        check("ar_hold_addr", axi.M_ARADDR, pa);
      end
      pw = ARESETN && axi.M_ARVALID && !axi.M_ARREADY;
      pa = axi.M_ARADDR;
    end
  end

  // ---------------- snapshot capture ----------------
  logic [3:0]  s_idx   [6];
  logic [31:0] s_data  [6];
  logic [31:0] s_delta [6];
  logic        s_first [6];
  logic        s_err   [6];
  logic        s_done  [6];

  // Returns at the negedge of the last expected snapshot.
  task automatic collect(input string tag);
    int n, cyc;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 2000) begin
      @(negedge ACLK);
      cyc++;
      if (snap_valid) begin
        s_idx[n] = snap_index;  s_data[n] = snap_data;  s_delta[n] = snap_delta;
        s_first[n] = snap_first; s_err[n] = snap_err;   s_done[n] = sweep_done;
        n++;
      end
    end
    if (n < 6) check({tag, "_timeout"}, n, 6);
  endtask

  initial begin
    int gap, cyc, arv_seen;
    logic seen;
    for (int i = 0; i < 16; i++) regs[i] = 32'd100 + 32'(i);

    repeat (3) @(negedge ACLK);
    check("rst_snap_valid", snap_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_arvalid", axi.M_ARVALID, 0);
    check("rst_rready", axi.M_RREADY, 0);
    check("rst_err_count", err_count, 0);
    check("rst_araddr", axi.M_ARADDR, 0);
    check("rst_sweep_done", sweep_done, 0);
    ARESETN = 1'b1;
    enable  = 1'b1;

    // Sweep 1: first reads, period 0
    collect("sweep1");
    for (int i = 0; i < 6; i++) begin
      check("s1_idx", s_idx[i], i);
      check("s1_data", s_data[i], 100 + i);
      check("s1_first", s_first[i], 1);
      check("s1_delta", s_delta[i], 0);
      check("s1_done", s_done[i], (i == 5));
    end
    check("s1_restart_arvalid", axi.M_ARVALID, 1);
    check("s1_restart_addr", axi.M_ARADDR, 32'h40);
    for (int i = 0; i < 6; i++) regs[i] = regs[i] + 32'd7;
    period = 32'd20;

    // Sweep 2: +7 everywhere, then 20-cycle wait
    collect("sweep2");
    for (int i = 0; i < 6; i++) begin
      check("s2_data", s_data[i], 107 + i);
      check("s2_delta", s_delta[i], 7);
      check("s2_first", s_first[i], 0);
      check("s2_err", s_err[i], 0);
    end
    check("s2_err_count", err_count, 0);
    regs[0] = 32'hFFFF_FFF0;
    err_idx = 3;
    gap = 0;
    while (!axi.M_ARVALID && gap < 100) begin
      gap++;
      @(negedge ACLK);
    end
    check("wait_gap", gap, 20);
    period = 32'd0;

    // Sweep 3: slave error on idx 3, large jump on idx 0
    collect("sweep3");
    check("s3_idx0_data", s_data[0], 32'hFFFF_FFF0);
    check("s3_idx0_delta", s_delta[0], 32'hFFFF_FF85);
    check("s3_idx3_err", s_err[3], 1);
    check("s3_idx3_delta", s_delta[3], 0);
    check("s3_idx2_err", s_err[2], 0);
    check("s3_err_count", err_count, 1);
    regs[0] = 32'h0000_0010;

    // Sweep 4: wrap on idx 0
    collect("sweep4");
    check("s4_wrap_delta", s_delta[0], 32'h20);
    check("s4_wrap_first", s_first[0], 0);
    check("s4_idx3_err", s_err[3], 1);
    check("s4_idx4_data", s_data[4], 111);
    check("s4_idx4_delta", s_delta[4], 0);
    check("s4_err_count", err_count, 2);

    collect("sweep5");
    check("s5_err_count", err_count, 3);
    collect("sweep6");
    check("s6_err_sat", err_count, 3);
    check("s6_idx3_err", s_err[3], 1);

    // Slow slave, then drop enable while idx 2 is in DATA
    err_idx  = 16;
    ar_delay = 5;
    r_delay  = 4;
    cyc = 0;
    while (!(axi.M_RREADY && axi.M_ARADDR[3:0] == 4'd2) && cyc < 500) begin
      cyc++;
      @(negedge ACLK);
    end
    check("idx2_data_reached", (cyc < 500), 1);
    enable = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge ACLK);
      cyc++;
      if (snap_valid) begin
        seen = 1'b1;
        check("stop_idx", snap_index, 2);
        check("stop_data", snap_data, 109);
        check("stop_delta", snap_delta, 0);
        check("stop_first", snap_first, 0);
        check("stop_busy", busy, 0);
      end
    end
    check("stop_snap_seen", seen, 1);
    arv_seen = 0;
    repeat (30) begin
      @(negedge ACLK);
      if (axi.M_ARVALID) arv_seen++;
    end
    check("stop_no_ar", arv_seen, 0);
    check("stop_idle_busy", busy, 0);

`ifdef STATS_POLLER_THRESH_EN
    check("irq_sticky", irq, 1);
    irq_clr = 1'b1;
    @(negedge ACLK);
    irq_clr = 1'b0;
    check("irq_clr_alone", irq, 0);
    regs[0]  = 32'h0000_001B;
    ar_delay = 0;
    r_delay  = 0;
    enable   = 1'b1;
    cyc = 0;
    while (!(axi.M_RVALID && axi.M_RREADY && axi.M_ARADDR[3:0] == 4'd0) && cyc < 200) begin
      cyc++;
      @(negedge ACLK);
    end
    check("irq_rd_reached", (cyc < 200), 1);
    irq_clr = 1'b1;
    @(negedge ACLK);
    irq_clr = 1'b0;
    check("irq_snap_valid", snap_valid, 1);
    check("irq_snap_delta", snap_delta, 11);
    check("irq_set_wins", irq, 1);
    repeat (10) @(negedge ACLK);
    check("irq_stays", irq, 1);
    enable = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge ACLK);
    end
    check("irq_end_idle", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
